// File: rtl/wb_regfile.sv
// Write-back stage register file: write-data mux, 2^ADDR_W x DATA_W registers,
// last-write record for forwarding and a commit counter. Define WB_BYPASS_EN for same-cycle read bypass.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic [DATA_W-1:0] Alu_result,
  input  logic [DATA_W-1:0] Read_data,
  input  logic [ADDR_W-1:0] MUX_destination,
  input  logic [ADDR_W-1:0] Read_reg1,
  input  logic [ADDR_W-1:0] Read_reg2,
  output logic [DATA_W-1:0] Read_data1,
  output logic [DATA_W-1:0] Read_data2,
  output logic [DATA_W-1:0] Write_data_out,
  output logic              Last_valid,
  output logic [ADDR_W-1:0] Last_dest,
  output logic [DATA_W-1:0] Last_data,
  output logic [31:0]       Wb_count
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic              lastValid_q, lastValid_d;
  logic [ADDR_W-1:0] lastDest_q, lastDest_d;
  logic [DATA_W-1:0] lastData_q, lastData_d;
  logic [31:0]       wbCount_q, wbCount_d;
  logic              commit;

  assign Write_data_out = MemtoReg_in ? Read_data : Alu_result;
  assign commit = !RST && RegWrite_in && (MUX_destination != '0);

  always_comb begin
    lastValid_d = commit;
    lastDest_d  = lastDest_q;
    lastData_d  = lastData_q;
    wbCount_d   = wbCount_q;
    if (commit) begin
      lastDest_d = MUX_destination;
      lastData_d = Write_data_out;
      wbCount_d  = wbCount_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      lastValid_q <= 1'b0;
      lastDest_q  <= '0;
      lastData_q  <= '0;
      wbCount_q   <= '0;
    end else begin
      if (commit) regs_q[MUX_destination] <= Write_data_out;
      lastValid_q <= lastValid_d;
      lastDest_q  <= lastDest_d;
      lastData_q  <= lastData_d;
      wbCount_q   <= wbCount_d;
    end
  end

  // Index 0 is hard-wired to zero regardless of what the array holds.
  always_comb begin
    Read_data1 = (Read_reg1 == '0) ? '0 : regs_q[Read_reg1];
    Read_data2 = (Read_reg2 == '0) ? '0 : regs_q[Read_reg2];
`ifdef WB_BYPASS_EN
    if (commit && (Read_reg1 == MUX_destination)) Read_data1 = Write_data_out;
    if (commit && (Read_reg2 == MUX_destination)) Read_data2 = Write_data_out;
`else
`endif
  end

  assign Last_valid = lastValid_q;
  assign Last_dest  = lastDest_q;
  assign Last_data  = lastData_q;
  assign Wb_count   = wbCount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic          CLK;
  logic          RST;
  logic          RegWrite_in;
  logic          MemtoReg_in;
  logic [DW-1:0] Alu_result;
  logic [DW-1:0] Read_data;
  logic [AW-1:0] MUX_destination;
  logic [AW-1:0] Read_reg1;
  logic [AW-1:0] Read_reg2;
  logic [DW-1:0] Read_data1;
  logic [DW-1:0] Read_data2;
  logic [DW-1:0] Write_data_out;
  logic          Last_valid;
  logic [AW-1:0] Last_dest;
  logic [DW-1:0] Last_data;
  logic [31:0]   Wb_count;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .Alu_result(Alu_result), .Read_data(Read_data), .MUX_destination(MUX_destination),
    .Read_reg1(Read_reg1), .Read_reg2(Read_reg2), .Read_data1(Read_data1),
    .Read_data2(Read_data2), .Write_data_out(Write_data_out), .Last_valid(Last_valid),
    .Last_dest(Last_dest), .Last_data(Last_data), .Wb_count(Wb_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: plain array of register contents plus last-write record.
  logic [DW-1:0] mdlRegs [NR];
  logic          mdlLastValid;
  logic [AW-1:0] mdlLastDest;
  logic [DW-1:0] mdlLastData;
  logic [31:0]   mdlCount;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NR; i++) mdlRegs[i] = '0;
    mdlLastValid = 1'b0;
    mdlLastDest  = '0;
    mdlLastData  = '0;
    mdlCount     = '0;
  endtask

  // Drives one cycle from a negedge, checks the combinational outputs, then the registered ones.
  task automatic applyStimulus(input logic rst, input logic rw, input logic m2r,
                               input logic [DW-1:0] alu, input logic [DW-1:0] rdd,
                               input logic [AW-1:0] dest, input logic [AW-1:0] r1,
                               input logic [AW-1:0] r2);
    logic [DW-1:0] wexp, e1, e2;
    logic          doWrite;
    RST = rst; RegWrite_in = rw; MemtoReg_in = m2r; Alu_result = alu; Read_data = rdd;
    MUX_destination = dest; Read_reg1 = r1; Read_reg2 = r2;
    #1;
    wexp    = m2r ? rdd : alu;
    doWrite = !rst && rw && (dest != 0);
    e1 = mdlRegs[r1];
    e2 = mdlRegs[r2];
`ifdef WB_BYPASS_EN
    if (doWrite && r1 == dest) e1 = wexp;
    if (doWrite && r2 == dest) e2 = wexp;
`endif
    checkOutput("Write_data_out", {32'd0, Write_data_out}, {32'd0, wexp});
    checkOutput("Read_data1", {32'd0, Read_data1}, {32'd0, e1});
    checkOutput("Read_data2", {32'd0, Read_data2}, {32'd0, e2});
    @(posedge CLK);
    if (rst) modelReset();
    else begin
      mdlLastValid = doWrite;
      if (doWrite) begin
        mdlRegs[dest] = wexp;
        mdlLastDest   = dest;
        mdlLastData   = wexp;
        mdlCount      = mdlCount + 32'd1;
      end
    end
    @(negedge CLK);
    checkOutput("Last_valid", {63'd0, Last_valid}, {63'd0, mdlLastValid});
    checkOutput("Last_dest", {59'd0, Last_dest}, {59'd0, mdlLastDest});
    checkOutput("Last_data", {32'd0, Last_data}, {32'd0, mdlLastData});
    checkOutput("Wb_count", {32'd0, Wb_count}, {32'd0, mdlCount});
  endtask

  initial begin
    RST = 1'b1; RegWrite_in = 1'b0; MemtoReg_in = 1'b0; Alu_result = '0; Read_data = '0;
    MUX_destination = '0; Read_reg1 = '0; Read_reg2 = '0;
    @(posedge CLK);
    @(negedge CLK);
    modelReset();
    checkOutput("reset_Wb_count", {32'd0, Wb_count}, 64'd0);
    checkOutput("reset_Last_valid", {63'd0, Last_valid}, 64'd0);

    // Every index on both ports reads zero after reset.
    for (int i = 0; i < NR; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, AW'(i), AW'(NR - 1 - i));

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h1234, 32'h9999, 5'd5, 5'd1, 5'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'hA, 32'h0, 5'd7, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'hB, 5'd7, 5'd7, 5'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF, 32'h5A5A, 5'd9, 5'd9, 5'd7);

    applyStimulus(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd3, 5'd3, 5'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd5);

    // Jump the commit counter to its maximum, then one commit wraps it.
    force dut.wbCount_q = 32'hFFFF_FFFF;
    #1;
    release dut.wbCount_q;
    mdlCount = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0, 5'd12, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd12);

    for (int n = 0; n < 400; n++) begin
      logic          rst, rw, m2r;
      logic [AW-1:0] dest, r1, r2;
      rst  = ($urandom_range(0, 29) == 0);
      rw   = ($urandom_range(0, 3) != 0);
      m2r  = 1'($urandom);
      dest = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      r1   = ($urandom_range(0, 2) == 0) ? dest : AW'($urandom);
      r2   = ($urandom_range(0, 2) == 0) ? dest : AW'($urandom);
      applyStimulus(rst, rw, m2r, $urandom, $urandom, dest, r1, r2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath and register width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width (2^ADDR_W registers).
REQ-003 The block SHALL have port CLK, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1, meaning reset; synchronous, active-high.
REQ-005 The block SHALL have port RegWrite_in, input, 1, meaning the write-back enable from the MEM/WB register.
REQ-006 The block SHALL have port MemtoReg_in, input, 1, meaning the select line: 1 picks Read_data, 0 picks Alu_result.
REQ-007 The block SHALL have ports Alu_result and Read_data, input, DATA_W each, meaning the write-back candidates.
REQ-008 The block SHALL have port MUX_destination, input, ADDR_W, meaning the destination register index.
REQ-009 The block SHALL have ports Read_reg1 and Read_reg2, input, ADDR_W each, meaning the decode-stage source indices.
REQ-010 The block SHALL have ports Read_data1 and Read_data2, output, DATA_W each, meaning the source operand values.
REQ-011 The block SHALL have port Write_data_out, output, DATA_W, meaning the selected write-back value.
REQ-012 The block SHALL have ports Last_valid (1), Last_dest (ADDR_W) and Last_data (DATA_W), output, meaning the registered record of the previous committed write, for the forwarding unit.
REQ-013 The block SHALL have port Wb_count, output, 32, meaning the count of committed writes.

Function
REQ-014 Write_data_out SHALL equal MemtoReg_in ? Read_data : Alu_result, combinationally and with zero latency.
REQ-015 A write SHALL commit at a rising CLK edge iff RST=0, RegWrite_in=1 and MUX_destination!=0.
REQ-016 A committed write SHALL store Write_data_out into register MUX_destination; the new value SHALL be readable from the following cycle.
REQ-017 Register 0 SHALL read as zero at all times; writes to index 0 SHALL be discarded and SHALL NOT count as commits.
REQ-018 Read_data1 and Read_data2 SHALL be combinational reads of the register array; both ports SHALL be independent and may address the same register.
REQ-019 On each commit, Last_valid SHALL become 1, and Last_dest and Last_data SHALL capture the index and data in the same edge; on a non-commit edge, Last_valid SHALL become 0 and Last_dest and Last_data SHALL hold.
REQ-020 Wb_count SHALL increment by 1 per commit and SHALL wrap from 0xFFFFFFFF to 0 without a flag.
REQ-021 RegWrite_in=1 with MemtoReg_in at either value SHALL behave identically apart from data selection; MemtoReg_in SHALL be ignored when RegWrite_in=0.

Reset
REQ-022 On a rising CLK edge with RST=1, all registers SHALL clear to 0, and Last_valid, Last_dest, Last_data and Wb_count SHALL clear to 0.
REQ-023 RST SHALL take priority over a simultaneous write; that write SHALL be lost and SHALL NOT be counted.
REQ-024 While RST=1, the same-cycle bypass SHALL be inhibited; reads SHALL return the array contents.
REQ-025 The block SHALL resume normal operation on the first edge after RST falls, including when RST rises in the middle of a write-back sequence.

Configuration
REQ-026 With macro WB_BYPASS_EN defined, a Read_regN equal to a committing MUX_destination (RegWrite_in=1, RST=0, index!=0) SHALL return Write_data_out in the same cycle, independently per port.
REQ-027 Without WB_BYPASS_EN, reads SHALL always return the stored array value, so same-cycle readers see the old value; all other behaviour SHALL be unchanged.

Verification
REQ-028 Reset then read all indices on both ports -> every Read_dataN=0, Wb_count=0, Last_valid=0.
REQ-029 RegWrite_in=1, MemtoReg_in=0, Alu_result=0x1234, dest=5, then next cycle Read_reg1=5 -> Read_data1=0x1234, Last_valid=1, Last_dest=5, Wb_count=1.
REQ-030 RegWrite_in=1, MemtoReg_in=1, Read_data=0xDEADBEEF, dest=0 -> Read_data1 for index 0 stays 0, Wb_count unchanged, Last_valid=0.
REQ-031 Register 7=0xA, then write 0xB to 7 with Read_reg1=Read_reg2=7 in the same cycle -> both read 0xB with WB_BYPASS_EN, 0xA without; both read 0xB on the next cycle.
REQ-032 RST=1 coincident with a write of 0x55 to register 3 -> register 3=0 afterwards, Wb_count=0.
REQ-033 Preload Wb_count to 0xFFFFFFFF via forced commits, then one more commit -> Wb_count=0 and data stored correctly.
